pwm_multi_shadow: RTL and testbench

- Multi-channel PWM generator. CHANNELS outputs share one period counter; each channel has its own duty value.
- Supports edge-aligned or center-aligned counting.
- Software writes period, duty and mode into shadow registers. The block moves them into the active registers only at a period boundary, so no output ever shows a glitched or partial period.
- Sits between the control-register block and the gate/LED drive pins. It is the multi-channel successor of the single-channel PWM core.

---
 rtl/pwm_multi_shadow_if.sv | 39 +++
 rtl/pwm_multi_shadow.sv | 158 +++++++++++++++
 tb/tb_pwm_multi_shadow.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_shadow_if.sv
// Control/drive bundle for pwm_multi_shadow. The complementary-output signals
// exist only when PWM_COMPL_EN is defined.
interface pwm_multi_shadow_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DT_WIDTH = 4
);
   logic                      load;
   logic [WIDTH-1:0]          period_in;
   logic [CHANNELS*WIDTH-1:0] duty_in;
   logic                      mode_in;
   logic [CHANNELS-1:0]       ch_en;
   logic [CHANNELS-1:0]       polarity;
   logic [CHANNELS-1:0]       pwm_out;
   logic                      period_start;
   logic                      update_pending;
`ifdef PWM_COMPL_EN
   logic [DT_WIDTH-1:0]       dead_time;
   logic [CHANNELS-1:0]       pwm_out_n;

   modport master (
      output load, period_in, duty_in, mode_in, ch_en, polarity, dead_time,
      input  pwm_out, pwm_out_n, period_start, update_pending
   );
   modport slave (
      input  load, period_in, duty_in, mode_in, ch_en, polarity, dead_time,
      output pwm_out, pwm_out_n, period_start, update_pending
   );
`else
   modport master (
      output load, period_in, duty_in, mode_in, ch_en, polarity,
      input  pwm_out, period_start, update_pending
   );
   modport slave (
      input  load, period_in, duty_in, mode_in, ch_en, polarity,
      output pwm_out, period_start, update_pending
   );
`endif
endinterface

// File: rtl/pwm_multi_shadow.sv
// Multi-channel PWM with shadowed period/duty/mode, edge or center counting.
// Define PWM_COMPL_EN to add complementary outputs with rising-edge dead time.

module pwm_multi_shadow_lane #(
   parameter int WIDTH    = 8,
   parameter int DT_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    cnt,
   input  logic [WIDTH-1:0]    duty,
   input  logic                en,
   input  logic                pol,
`ifdef PWM_COMPL_EN
   input  logic [DT_WIDTH-1:0] dead_time,
   output logic                out_n,
`endif
   output logic                out
);
   logic lvl;

   assign lvl = en ? ((cnt < duty) ^ pol) : pol;

`ifdef PWM_COMPL_EN
   // Target pair {high side, low side}; 00 while disabled, so re-enabling
   // also counts as an edge and gets the dead-time delay.
   logic [1:0]          tgt, tgt_q;
   logic [DT_WIDTH-1:0] dtc, dtc_nxt;

   assign tgt = {en & lvl, en & ~lvl};

   always_comb begin
      dtc_nxt = dtc;
      if (tgt != tgt_q)
         dtc_nxt = dead_time;
      else if (dtc != '0)
         dtc_nxt = dtc - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_q <= '0;
         dtc   <= '0;
         out   <= 1'b0;
         out_n <= 1'b0;
      end else begin
         tgt_q <= tgt;
         dtc   <= dtc_nxt;
         out   <= tgt[1] & (dtc_nxt == '0);
         out_n <= tgt[0] & (dtc_nxt == '0);
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) out <= 1'b0;
      else     out <= lvl;
   end
`endif
endmodule

module pwm_multi_shadow #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DT_WIDTH = 4
) (
   input logic                clk,
   input logic                rst,
   pwm_multi_shadow_if.slave  bus
);
   typedef struct packed {
      logic                           mode;
      logic [WIDTH-1:0]               period;
      logic [CHANNELS-1:0][WIDTH-1:0] duty;
   } cfg_t;

   cfg_t                act, shd, req;
   logic [WIDTH-1:0]    cnt, cnt_nxt, pe;
   logic                dir, dir_nxt;
   logic                boundary, pending, start;
   logic [CHANNELS-1:0] pwm;

   assign req = {bus.mode_in, bus.period_in, bus.duty_in};
   assign pe  = (act.period == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : act.period;

   // dir: 0 = up, 1 = down. Center mode visits 0..Pe-1 up, then Pe-1..0 down.
   always_comb begin
      cnt_nxt  = cnt;
      dir_nxt  = dir;
      boundary = 1'b0;
      if (!act.mode) begin
         dir_nxt = 1'b0;
         if (cnt >= act.period) boundary = 1'b1;
         else                   cnt_nxt  = cnt + 1'b1;
      end else if (!dir) begin
         if (cnt >= pe - 1'b1) dir_nxt = 1'b1;
         else                  cnt_nxt = cnt + 1'b1;
      end else begin
         if (cnt == '0) boundary = 1'b1;
         else           cnt_nxt  = cnt - 1'b1;
      end
      if (boundary) begin
         cnt_nxt = '0;
         dir_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         dir     <= 1'b0;
         act     <= '0;
         shd     <= '0;
         pending <= 1'b0;
         start   <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         dir   <= dir_nxt;
         start <= boundary;
         if (bus.load) shd <= req;
         // A load on the boundary edge bypasses the shadow entirely.
         if (boundary) begin
            if (bus.load)    act <= req;
            else if (pending) act <= shd;
            pending <= 1'b0;
         end else if (bus.load) begin
            pending <= 1'b1;
         end
      end
   end

`ifdef PWM_COMPL_EN
   logic [CHANNELS-1:0] pwm_n;
   assign bus.pwm_out_n = pwm_n;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      pwm_multi_shadow_lane #(
         .WIDTH    (WIDTH),
         .DT_WIDTH (DT_WIDTH)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .cnt       (cnt),
         .duty      (act.duty[i]),
         .en        (bus.ch_en[i]),
         .pol       (bus.polarity[i]),
`ifdef PWM_COMPL_EN
         .dead_time (bus.dead_time),
         .out_n     (pwm_n[i]),
`endif
         .out       (pwm[i])
      );
   end

   assign bus.pwm_out        = pwm;
   assign bus.period_start   = start;
   assign bus.update_pending = pending;
endmodule

// File: tb/tb_pwm_multi_shadow.sv
// Directed + randomized bench for pwm_multi_shadow against a period-sequence model.
module tb_pwm_multi_shadow;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int DT_WIDTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pwm_multi_shadow_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DT_WIDTH(DT_WIDTH)) bus ();
   pwm_multi_shadow #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DT_WIDTH(DT_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int errors  = 0;

   // Model: active/shadow config and the list of counter values of the current period.
   int m_act_p, m_shd_p;
   bit m_act_mode, m_shd_mode, m_pend;
   int m_act_d[CHANNELS];
   int m_shd_d[CHANNELS];
   int seq[$];
   int idx;
   logic [1:0] last[CHANNELS];
   int run[CHANNELS];

   int hi_cnt[CHANNELS];
   int n_cnt[CHANNELS];
   int start_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic void build_seq();
      int pe;
      seq.delete();
      if (!m_act_mode) begin
         for (int k = 0; k <= m_act_p; k++) seq.push_back(k);
      end else begin
         pe = (m_act_p == 0) ? 1 : m_act_p;
         for (int k = 0; k < pe; k++) seq.push_back(k);
         for (int k = pe - 1; k >= 0; k--) seq.push_back(k);
      end
   endfunction

   function automatic void model_reset();
      m_act_p = 0; m_act_mode = 0; m_shd_p = 0; m_shd_mode = 0; m_pend = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         m_act_d[i] = 0; m_shd_d[i] = 0; last[i] = 2'b00; run[i] = 0;
      end
      build_seq();
      idx = 0;
   endfunction

   function automatic void take_inputs_active();
      m_act_p    = int'(bus.period_in);
      m_act_mode = bus.mode_in;
      for (int i = 0; i < CHANNELS; i++) m_act_d[i] = int'(bus.duty_in[i*WIDTH +: WIDTH]);
   endfunction

   task automatic tick();
      logic [CHANNELS-1:0] eo, eon;
      logic es, lvl;
      logic [1:0] tgt;
      int c, dt;
      eo = '0; eon = '0; es = 1'b0;
      dt = 0;
`ifdef PWM_COMPL_EN
      dt = int'(bus.dead_time);
`endif
      if (rst) begin
         model_reset();
      end else begin
         c = seq[idx];
         for (int i = 0; i < CHANNELS; i++) begin
            lvl = bus.ch_en[i] ? ((c < m_act_d[i]) ^ bus.polarity[i]) : bus.polarity[i];
            tgt = {bus.ch_en[i] & lvl, bus.ch_en[i] & ~lvl};
            if (tgt == last[i]) run[i]++;
            else run[i] = 1;
            last[i] = tgt;
`ifdef PWM_COMPL_EN
            eo[i]  = tgt[1] && (run[i] > dt);
            eon[i] = tgt[0] && (run[i] > dt);
`else
            eo[i]  = lvl;
`endif
         end
         es = (idx == seq.size() - 1);
         if (es) begin
            if (bus.load) take_inputs_active();
            else if (m_pend) begin
               m_act_p = m_shd_p; m_act_mode = m_shd_mode;
               for (int i = 0; i < CHANNELS; i++) m_act_d[i] = m_shd_d[i];
            end
            m_pend = 0;
            build_seq();
            idx = 0;
         end else begin
            idx++;
            if (bus.load) m_pend = 1;
         end
         if (bus.load) begin
            m_shd_p = int'(bus.period_in); m_shd_mode = bus.mode_in;
            for (int i = 0; i < CHANNELS; i++) m_shd_d[i] = int'(bus.duty_in[i*WIDTH +: WIDTH]);
         end
      end
      @(posedge clk);
      #1;
      check("pwm_out", 32'(bus.pwm_out), 32'(eo));
      check("period_start", 32'(bus.period_start), 32'(es));
      check("update_pending", 32'(bus.update_pending), 32'(m_pend));
`ifdef PWM_COMPL_EN
      check("pwm_out_n", 32'(bus.pwm_out_n), 32'(eon));
`endif
      for (int i = 0; i < CHANNELS; i++) begin
         hi_cnt[i] += int'(bus.pwm_out[i]);
`ifdef PWM_COMPL_EN
         n_cnt[i] += int'(bus.pwm_out_n[i]);
`endif
      end
      start_cnt += int'(bus.period_start);
      if (eon == '1) dt = 0;
   endtask

   task automatic set_cfg(input int p, input bit mode, input int d0, input int d1, input int d2, input int d3);
      bus.period_in = WIDTH'(p);
      bus.mode_in   = mode;
      bus.duty_in   = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
   endtask

   task automatic do_load(input int p, input bit mode, input int d0, input int d1, input int d2, input int d3);
      set_cfg(p, mode, d0, d1, d2, d3);
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic window(input int n);
      for (int i = 0; i < CHANNELS; i++) begin hi_cnt[i] = 0; n_cnt[i] = 0; end
      start_cnt = 0;
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic wait_start(input string tag);
      int g;
      g = 0;
      while (bus.period_start !== 1'b1 && g < 100) begin tick(); g++; end
      if (g >= 100) begin
         vectors++; errors++;
         $display("FAIL %s: period_start not seen within 100 cycles", tag);
      end
   endtask

   task automatic wait_cnt(input string tag, input int v);
      int g;
      g = 0;
      while (seq[idx] != v && g < 100) begin tick(); g++; end
      if (g >= 100) begin
         vectors++; errors++;
         $display("FAIL %s: counter value %0d not reached within 100 cycles", tag, v);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.load = 1'b0; bus.ch_en = '1; bus.polarity = '0;
      set_cfg(0, 0, 0, 0, 0, 0);
`ifdef PWM_COMPL_EN
      bus.dead_time = '0;
`endif
      model_reset();
      start_cnt = 0;
      tick(); tick();
      check("reset_out", 32'(bus.pwm_out), 32'h0);
      rst = 1'b0;

      // Edge mode P=9 applied on the post-reset boundary (P=0 -> boundary every cycle).
      do_load(9, 0, 3, 0, 10, 255);
      window(20);
      check("edge_d3_highs", hi_cnt[0], 6);
      check("edge_d0_highs", hi_cnt[1], 0);
      check("edge_d10_highs", hi_cnt[2], 20);
      check("edge_d255_highs", hi_cnt[3], 20);
      check("edge_starts", start_cnt, 2);

      bus.polarity = '1;
      window(20);
      check("inv_d3_highs", hi_cnt[0], 14);
      check("inv_d0_highs", hi_cnt[1], 20);
      check("inv_d10_highs", hi_cnt[2], 0);
      check("inv_d255_highs", hi_cnt[3], 0);
      bus.polarity = '0;

      // Mid-period shadow load at cnt=4.
      wait_cnt("mid_cnt4", 4);
      do_load(9, 0, 5, 0, 10, 255);
      check("mid_pending", 32'(bus.update_pending), 32'h1);
      wait_start("mid_boundary");
      window(10);
      check("mid_next_highs", hi_cnt[0], 5);

      // Center mode P=8, then P=0.
      do_load(8, 1, 3, 0, 10, 255);
      tick();
      wait_start("ctr8_boundary");
      window(16);
      check("ctr8_highs", hi_cnt[0], 6);
      check("ctr8_starts", start_cnt, 1);
      do_load(0, 1, 3, 0, 10, 255);
      tick();
      wait_start("ctr0_boundary");
      window(8);
      check("ctr0_starts", start_cnt, 4);
      check("ctr0_highs", hi_cnt[0], 8);

      // Load coincident with cnt==P.
      do_load(9, 0, 3, 0, 10, 255);
      tick();
      wait_start("coin_setup");
      wait_cnt("coin_cnt9", 9);
      do_load(9, 0, 7, 0, 10, 255);
      check("coin_no_pending", 32'(bus.update_pending), 32'h0);
      window(10);
      check("coin_highs", hi_cnt[0], 7);

      // Reset mid-period discards the pending update.
      tick(); tick(); tick();
      do_load(9, 0, 2, 2, 2, 2);
      check("rst_pending_set", 32'(bus.update_pending), 32'h1);
      tick();
      rst = 1'b1;
      tick();
      check("rst_out_zero", 32'(bus.pwm_out), 32'h0);
      check("rst_pending_clr", 32'(bus.update_pending), 32'h0);
      rst = 1'b0;
      window(12);
      check("rst_dropped_highs", hi_cnt[0], 0);

`ifdef PWM_COMPL_EN
      rst = 1'b1; bus.dead_time = DT_WIDTH'(2); tick(); rst = 1'b0;
      do_load(9, 0, 5, 5, 5, 5);
      window(20);
      check("dt2_out_highs", hi_cnt[0], 6);
      check("dt2_outn_highs", n_cnt[0], 6);
      rst = 1'b1; bus.dead_time = '0; tick(); rst = 1'b0;
      do_load(9, 0, 5, 5, 5, 5);
      window(20);
      check("dt0_out_highs", hi_cnt[0], 10);
      check("dt0_outn_highs", n_cnt[0], 10);
`endif

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
`ifdef PWM_COMPL_EN
            bus.dead_time = DT_WIDTH'($urandom_range(0, 3));
`endif
         end
         if ($urandom_range(0, 39) == 0) begin
            bus.ch_en    = CHANNELS'($urandom);
            bus.polarity = CHANNELS'($urandom);
         end
         if ($urandom_range(0, 7) == 0) begin
            set_cfg($urandom_range(0, 12), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 15));
            bus.load = 1'b1;
         end
         tick();
         bus.load = 1'b0;
         rst = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
